// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// Latency 1 cycle from handshake to rf_we; hold or reset blocks acceptance, and hazard checks are combinational.
module rf_write_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic                 hold,
   output logic                 rf_we,
   output logic [AW-1:0]        rf_waddr,
   output logic [DW-1:0]        rf_wdata,
   output logic [1:0]           grant_id,
   input  logic [AW-1:0]        chk_addr1,
   input  logic [AW-1:0]        chk_addr2,
   output logic                 chk_busy1,
   output logic                 chk_busy2
);

   logic [1:0]    ptr_q, ptr_d, gid_q, gid_d, win;
   logic          rf_we_q, rf_we_d, found, hs;
   logic [AW-1:0] waddr_q, waddr_d, sel_addr;
   logic [DW-1:0] wdata_q, wdata_d, sel_data;
   logic [2:0]    idx, nxt;
   logic [7:0]    vld_pad;

   // Padded so a 3-bit rotated index always selects in range.
   assign vld_pad = 8'(req_valid);

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + 3'(k);
         if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
         if (!found && vld_pad[idx]) begin
            found = 1'b1;
            win   = idx[1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_addr  = '0;
      sel_data  = '0;
      hs        = found & ~hold & ~rst;
      for (int i = 0; i < NREQ; i++) begin
         if (win == 2'(i)) begin
            sel_addr     = req_addr[i*AW +: AW];
            sel_data     = req_data[i*DW +: DW];
            req_ready[i] = hs;
         end
      end
      nxt = {1'b0, win} + 3'd1;
      if (nxt >= 3'(NREQ)) nxt = '0;
      ptr_d   = hs ? nxt[1:0] : ptr_q;
      gid_d   = hs ? win : gid_q;
      waddr_d = hs ? sel_addr : waddr_q;
      wdata_d = hs ? sel_data : wdata_q;
      // r0 writes complete the handshake but never reach the register file.
      rf_we_d = hs && (sel_addr != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         gid_q   <= '0;
         rf_we_q <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         rf_we_q <= rf_we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      chk_busy1 = rf_we_q && (waddr_q == chk_addr1);
      chk_busy2 = rf_we_q && (waddr_q == chk_addr2);
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_addr[i*AW +: AW] == chk_addr1) chk_busy1 = 1'b1;
         if (req_valid[i] && req_addr[i*AW +: AW] == chk_addr2) chk_busy2 = 1'b1;
      end
      if (chk_addr1 == '0) chk_busy1 = 1'b0;
      if (chk_addr2 == '0) chk_busy2 = 1'b0;
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
   assign grant_id = gid_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: per-cycle behavioural model plus directed literal checks.
module tb_rf_write_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*AW-1:0]  req_addr;
   logic [NREQ*DW-1:0]  req_data;
   logic                hold;
   logic                rf_we;
   logic [AW-1:0]       rf_waddr;
   logic [DW-1:0]       rf_wdata;
   logic [1:0]          grant_id;
   logic [AW-1:0]       chk_addr1, chk_addr2;
   logic                chk_busy1, chk_busy2;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: what the registered outputs must be.
   int          m_ptr;
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_gid;

   rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .hold(hold),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .grant_id(grant_id),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
      .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] addr_of(input int i);
      return req_addr[i*AW +: AW];
   endfunction

   function automatic logic model_busy(input logic [4:0] a);
      logic b;
      if (a == 5'd0) return 1'b0;
      b = m_we && (m_waddr == a);
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i] && addr_of(i) == a) b = 1'b1;
      return b;
   endfunction

   // Compare every cycle at the negedge, then advance the model across the coming posedge.
   always @(negedge clk) begin
      int w;
      logic [2:0] exp_rdy;
      if (rst) begin
         m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_gid = 0;
      end
      w = -1;
      if (!rst)
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      exp_rdy = (w >= 0 && !hold && !rst) ? 3'(1 << w) : 3'b000;
      chk("m_ready", 32'(req_ready), 32'(exp_rdy));
      chk("m_we", 32'(rf_we), 32'(m_we));
      chk("m_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("m_wdata", rf_wdata, m_wdata);
      chk("m_gid", 32'(grant_id), 32'(m_gid));
      chk("m_busy1", 32'(chk_busy1), 32'(model_busy(chk_addr1)));
      chk("m_busy2", 32'(chk_busy2), 32'(model_busy(chk_addr2)));
      if (exp_rdy != 3'b000) begin
         m_we    = (addr_of(w) != 5'd0);
         m_waddr = addr_of(w);
         m_wdata = req_data[w*DW +: DW];
         m_gid   = w;
         m_ptr   = (w + 1) % NREQ;
      end else begin
         m_we = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   initial begin
      logic [1:0] seq [6];
      seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
      rst = 1'b1; req_valid = '1; req_addr = '0; req_data = '0; hold = 1'b0;
      chk_addr1 = '0; chk_addr2 = '0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_waddr", 32'(rf_waddr), 32'd0);
      chk("rst_wdata", rf_wdata, 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      req_valid = '0;
      step(); step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("idle_we", 32'(rf_we), 32'd0);
      end

      // Single write from requester 1.
      req_valid = 3'b010; set_req(1, 5'd5, 32'hDEADBEEF);
      #1 chk("single_ready", 32'(req_ready), 32'h2);
      step(); req_valid = '0;
      chk("single_we", 32'(rf_we), 32'd1);
      chk("single_waddr", 32'(rf_waddr), 32'd5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      chk("single_gid", 32'(grant_id), 32'd1);
      step();
      chk("single_we_off", 32'(rf_we), 32'd0);

      // Fairness from a fresh reset with all three requesters valid.
      rst = 1'b1;
      step();
      req_valid = 3'b111;
      set_req(0, 5'd1, 32'h11); set_req(1, 5'd2, 32'h22); set_req(2, 5'd3, 32'h33);
      rst = 1'b0;
      #1 chk("fair_ready0", 32'(req_ready), 32'h1);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("fair_gid", 32'(grant_id), 32'(seq[c]));
         chk("fair_we", 32'(rf_we), 32'd1);
      end

      // Asynchronous reset while rf_we is high.
      #2 rst = 1'b1;
      #1;
      chk("arst_we", 32'(rf_we), 32'd0);
      chk("arst_gid", 32'(grant_id), 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd0);
      step(); rst = 1'b0;
      #1 chk("arst_ptr0", 32'(req_ready), 32'h1);
      req_valid = '0;
      step();

      // Write to r0 is accepted but dropped.
      req_valid = 3'b100; set_req(2, 5'd0, 32'hFFFFFFFF); chk_addr2 = 5'd0;
      #1 chk("r0_ready", 32'(req_ready), 32'h4);
      chk("r0_busy2", 32'(chk_busy2), 32'd0);
      step(); req_valid = '0;
      chk("r0_gid", 32'(grant_id), 32'd2);
      chk("r0_we", 32'(rf_we), 32'd0);
      step();

      // Hazard window under hold, then drain.
      chk_addr1 = 5'd7; hold = 1'b1; req_valid = 3'b001; set_req(0, 5'd7, 32'h77);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("haz_busy_hold", 32'(chk_busy1), 32'd1);
         chk("haz_ready_hold", 32'(req_ready), 32'd0);
         step();
      end
      hold = 1'b0;
      #1 chk("haz_ready", 32'(req_ready), 32'h1);
      chk("haz_busy_req", 32'(chk_busy1), 32'd1);
      step(); req_valid = '0;
      chk("haz_we", 32'(rf_we), 32'd1);
      chk("haz_busy_we", 32'(chk_busy1), 32'd1);
      step();
      chk("haz_busy_done", 32'(chk_busy1), 32'd0);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
